// File: rtl/spi_pixel_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : spi_pixel_pkg
//  Description : Shared definitions for the SPI pixel receiver: receive FSM
//                state encoding, default geometry and helper functions that
//                derive the pixel, word and bit-counter widths from the
//                CHANNELS / BITS_PER_CHANNEL parameters of the top level.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pixel_pkg;

  // Receive FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  // Default geometry (4 bytes per pixel, 4 MSBs kept per byte)
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_BPC       = 4;
  localparam int PIXEL_W       = DEF_CHANNELS * DEF_BPC;
  localparam int WORD_BITS     = 8 * DEF_CHANNELS;
  localparam int CNT_W         = $clog2(WORD_BITS + 1);

  // Width helpers for non-default parameterisations
  function automatic int pixel_width(input int channels, input int bpc);
    return channels * bpc;
  endfunction

  function automatic int word_bits(input int channels);
    return 8 * channels;
  endfunction

  function automatic int cnt_width(input int channels);
    return $clog2(8 * channels + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pixel_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous FIFO carrying {frame_start, pixel} entries.
//                A push while full is accepted when a pop happens in the
//                same cycle. The read port shows zero while empty.
//  Ports       : clk        system clock
//                reset_n    synchronous active-low reset
//                push       write request, push_data written when accepted
//                pop        read acknowledge, ignored when empty
//                pop_data   head entry (zero when empty)
//                full/empty occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Full is not a blocker when the head leaves in the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_pixel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pixel_rx
//  Description : Oversampling SPI mode-0 pixel receiver. Assembles CHANNELS
//                bytes per word, keeps the top BITS_PER_CHANNEL bits of each
//                byte and queues packed pixels for the frame writer.
//                Chip-select framing, frame-start tagging, short-word
//                detection and sticky overflow.
//  Option      : SPI_PIXEL_RX_STATS_EN adds pixel_count, drop_count and
//                short_count statistics outputs.
//  Ports       : sys_clk / reset_n        clock, sync active-low reset
//                spi_sck/spi_mosi/spi_cs_n asynchronous SPI inputs
//                pixel_data/pixel_frame_start/pixel_valid/pixel_ready
//                                         pixel stream to consumer
//                overflow / overflow_clr  sticky drop flag and its clear
//                short_word               pulse on truncated word
//  Revision    : 1.0  initial release
// ============================================================================
module spi_pixel_rx
  import spi_pixel_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                                 sys_clk,
  input  logic                                 reset_n,
  input  logic                                 spi_sck,
  input  logic                                 spi_mosi,
  input  logic                                 spi_cs_n,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] pixel_data,
  output logic                                 pixel_frame_start,
  output logic                                 pixel_valid,
  input  logic                                 pixel_ready,
  output logic                                 overflow,
  input  logic                                 overflow_clr,
`ifdef SPI_PIXEL_RX_STATS_EN
  output logic [15:0]                          pixel_count,
  output logic [15:0]                          drop_count,
  output logic [7:0]                           short_count,
`endif
  output logic                                 short_word
);

  localparam int PW    = pixel_width(CHANNELS, BITS_PER_CHANNEL);
  localparam int WB    = word_bits(CHANNELS);
  localparam int CW    = cnt_width(CHANNELS);

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_prev;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_s;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------- receive
  logic [0:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [PW-1:0] kept;
  logic          first_flag;
  logic          shift_in;
  logic          keep_bit;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_after;
  logic          word_done;
  logic          short_set;
  logic [PW-1:0] packed_word;

  assign shift_in  = sck_s & ~sck_prev & (state == ST_RECV);
  // Only the first BITS_PER_CHANNEL bits of every byte are stored, so the
  // kept register already holds the packed pixel once the word completes.
  assign keep_bit  = ({1'b0, bit_cnt[2:0]} < 4'(BITS_PER_CHANNEL));
  assign cnt_inc   = bit_cnt + 1'b1;
  assign word_done = shift_in & (cnt_inc == CW'(WB));
  assign cnt_after = shift_in ? (word_done ? '0 : cnt_inc) : bit_cnt;
  // Measured after this cycle's shift, so a word completing together with
  // the cs_n rise is pushed rather than reported as short.
  assign short_set = (state == ST_RECV) & cs_s & (cnt_after != '0);

  // Last bit of the word is still on mosi_s when it is kept (BPC == 8)
  assign packed_word = keep_bit ? {kept[PW-2:0], mosi_s} : kept;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      kept       <= '0;
      first_flag <= 1'b0;
      short_word <= 1'b0;
    end else begin
      short_word <= short_set;
      case (state)
        ST_IDLE: begin
          if (!cs_s) begin
            bit_cnt    <= '0;
            first_flag <= 1'b1;
            state      <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (shift_in && keep_bit) begin
            kept <= {kept[PW-2:0], mosi_s};
          end
          bit_cnt <= cnt_after;
          if (word_done) begin
            first_flag <= 1'b0;
          end
          if (cs_s) begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [PW:0] fifo_out;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;

  assign pop  = pixel_valid & pixel_ready;
  assign drop = word_done & fifo_full & ~pop;

  pixel_fifo #(
    .WIDTH (PW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .reset_n   (reset_n),
    .push      (word_done),
    .push_data ({first_flag, packed_word}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pixel_valid       = ~fifo_empty;
  assign pixel_data        = fifo_out[PW-1:0];
  assign pixel_frame_start = fifo_out[PW];

  // A drop in the same cycle as a clear wins, so no drop goes unnoticed
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef SPI_PIXEL_RX_STATS_EN
  logic accepted;
  assign accepted = word_done & (~fifo_full | pop);

  always_ff @(posedge sys_clk) begin
    if (!reset_n || overflow_clr) begin
      pixel_count <= '0;
      drop_count  <= '0;
      short_count <= '0;
    end else begin
      if (accepted) pixel_count <= pixel_count + 16'd1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (short_set && short_count != 8'hFF) short_count <= short_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire
